// File: rtl/capture_pkg.sv
// Shared types and constants for the frame-capture sequencer: FSM state encoding,
// Avalon register map, CTRL bit positions and the default capture window geometry.
package capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_INDEX  = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;

  localparam int unsigned DEFAULT_WIN_X0   = 208;
  localparam int unsigned DEFAULT_WIN_Y0   = 128;
  localparam int unsigned DEFAULT_WIN_SIZE = 224;

  function automatic logic [31:0] pack_status(cap_state_e st, logic [7:0] frames,
                                              logic [15:0] pixels);
    return {pixels, frames, 5'b0, st == StDone, st};
  endfunction

endpackage

// File: rtl/capture_controller_if.sv
// Bundle of the Avalon register port, synchronized pixel stream and capture buffer port.
// slave: the capture controller; master: the surrounding system (host, pixel source, RAM).
interface capture_controller_if;

  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] writedata;
  logic [31:0] readdata;

  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [7:0]  pix_luma;

  logic        buf_wr_en;
  logic [15:0] buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic [15:0] buf_rd_addr;
  logic [7:0]  buf_rd_data;

  logic        cap_done;

  modport slave (
    input  addr, rd_en, wr_en, writedata, pix_valid, pix_x, pix_y, pix_luma, buf_rd_data,
    output readdata, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr, cap_done
  );

  modport master (
    output addr, rd_en, wr_en, writedata, pix_valid, pix_x, pix_y, pix_luma, buf_rd_data,
    input  readdata, buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_addr, cap_done
  );

endinterface

// File: rtl/capture_addr_gen.sv
// Combinational window membership test and row-major buffer address for a screen sample.
module capture_addr_gen
  import capture_pkg::*;
#(
  parameter int unsigned WIN_X0   = DEFAULT_WIN_X0,
  parameter int unsigned WIN_Y0   = DEFAULT_WIN_Y0,
  parameter int unsigned WIN_SIZE = DEFAULT_WIN_SIZE
) (
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic        in_win,
  output logic [15:0] addr
);

  localparam logic [15:0] XLo  = 16'(WIN_X0);
  localparam logic [15:0] XHi  = 16'(WIN_X0 + WIN_SIZE);
  localparam logic [15:0] YLo  = 16'(WIN_Y0);
  localparam logic [15:0] YHi  = 16'(WIN_Y0 + WIN_SIZE);
  localparam logic [15:0] Size = 16'(WIN_SIZE);

  logic [15:0] x16;
  logic [15:0] y16;

  assign x16    = {5'b0, pix_x};
  assign y16    = {5'b0, pix_y};
  assign in_win = (x16 >= XLo) && (x16 < XHi) && (y16 >= YLo) && (y16 < YHi);
  assign addr   = Size * (y16 - YLo) + (x16 - XLo);

endmodule

// File: rtl/capture_controller.sv
// Frame-capture sequencer: arms on host START, captures one window beginning at a frame boundary,
// then freezes the buffer for INDEX/DATA readout. Define CAPTURE_AUTOINC_EN to step INDEX on DATA reads.
module capture_controller
  import capture_pkg::*;
#(
  parameter int unsigned WIN_X0   = DEFAULT_WIN_X0,
  parameter int unsigned WIN_Y0   = DEFAULT_WIN_Y0,
  parameter int unsigned WIN_SIZE = DEFAULT_WIN_SIZE
) (
  input logic                 clk,
  input logic                 reset_n,
  capture_controller_if.slave bus
);

  localparam int unsigned Depth    = WIN_SIZE * WIN_SIZE;
  localparam logic [15:0] LastAddr = 16'(Depth - 1);

  cap_state_e  state_q;
  logic [31:0] readdata_q;
  logic        buf_wr_en_q;
  logic [15:0] buf_wr_addr_q;
  logic [7:0]  buf_wr_data_q;
  logic [15:0] index_q;
  logic [15:0] pix_count_q;
  logic [7:0]  frame_count_q;
  logic        have_prev_q;

  logic        in_win;
  logic [15:0] win_addr;

  capture_addr_gen #(
    .WIN_X0  (WIN_X0),
    .WIN_Y0  (WIN_Y0),
    .WIN_SIZE(WIN_SIZE)
  ) u_addr_gen (
    .pix_x (bus.pix_x),
    .pix_y (bus.pix_y),
    .in_win(in_win),
    .addr  (win_addr)
  );

  logic        ctrl_wr;
  logic        abort;
  logic        start;
  logic        index_wr;
  logic        win_wr;
  logic        is_new_addr;
  logic        frame_start;
  logic        index_in_range;
  logic [31:0] rd_value;
  logic        unused_wdata;

  assign ctrl_wr        = bus.wr_en && (bus.addr == REG_CTRL);
  assign abort          = ctrl_wr && bus.writedata[CTRL_ABORT_BIT];
  assign start          = ctrl_wr && bus.writedata[CTRL_START_BIT] && !abort;
  assign index_wr       = bus.wr_en && (bus.addr == REG_INDEX);
  assign win_wr         = (state_q == StCapture) && bus.pix_valid && in_win && !abort;
  // Synchronizer duplicates rewrite the same address; only fresh addresses are counted.
  assign is_new_addr    = !have_prev_q || (win_addr != buf_wr_addr_q);
  assign frame_start    = bus.pix_valid && (bus.pix_x == '0) && (bus.pix_y == '0);
  assign index_in_range = 32'(index_q) < Depth;
  assign unused_wdata   = ^bus.writedata[31:16];

`ifdef CAPTURE_AUTOINC_EN
  logic data_rd;
  assign data_rd = bus.rd_en && (bus.addr == REG_DATA);
`endif

  always_comb begin
    rd_value = '0;
    case (bus.addr)
      REG_STATUS: rd_value = pack_status(state_q, frame_count_q, pix_count_q);
      REG_INDEX:  rd_value = {16'b0, index_q};
      REG_DATA:   rd_value = index_in_range ? {24'b0, bus.buf_rd_data} : '0;
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      readdata_q    <= '0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      index_q       <= '0;
      pix_count_q   <= '0;
      frame_count_q <= '0;
      have_prev_q   <= 1'b0;
    end else begin
      buf_wr_en_q <= win_wr;
      if (win_wr) begin
        buf_wr_addr_q <= win_addr;
        buf_wr_data_q <= bus.pix_luma;
        have_prev_q   <= 1'b1;
        if (is_new_addr) pix_count_q <= pix_count_q + 16'd1;
      end

      if (bus.rd_en) readdata_q <= rd_value;

      if (index_wr) begin
        index_q <= bus.writedata[15:0];
      end
`ifdef CAPTURE_AUTOINC_EN
      else if (data_rd) begin
        index_q <= (index_q >= LastAddr) ? '0 : index_q + 16'd1;
      end
`endif

      if (abort) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (start) begin
              state_q     <= StArmed;
              pix_count_q <= '0;
              have_prev_q <= 1'b0;
            end
          end
          StArmed: begin
            if (frame_start) state_q <= StCapture;
          end
          StCapture: begin
            if (win_wr && (win_addr == LastAddr)) begin
              state_q       <= StDone;
              frame_count_q <= frame_count_q + 8'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.buf_wr_en   = buf_wr_en_q;
  assign bus.buf_wr_addr = buf_wr_addr_q;
  assign bus.buf_wr_data = buf_wr_data_q;
  assign bus.buf_rd_addr = index_q;
  assign bus.cap_done    = (state_q == StDone);

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: register table, randomized pixel streams
// against a frame-level reference model, plus abort / duplicate / mid-capture reset sequences.
module tb_capture_controller;
  import capture_pkg::*;

  // Reduced window keeps multiple full captures within a short run.
  localparam int WX0   = 208;
  localparam int WY0   = 128;
  localparam int WS    = 40;
  localparam int DEPTH = WS * WS;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  capture_controller_if bus ();

  capture_controller #(
    .WIN_X0  (WX0),
    .WIN_Y0  (WY0),
    .WIN_SIZE(WS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [7:0] ram [0:65535];
  always @(posedge clk) if (bus.buf_wr_en) ram[bus.buf_wr_addr] <= bus.buf_wr_data;
  assign bus.buf_rd_data = ram[bus.buf_rd_addr];

  int total = 0;
  int bad   = 0;

  // Reference model: state 0 idle, 1 armed, 2 capture, 3 done.
  int         m_state, m_pix, m_frame, m_last, m_idx;
  logic [7:0] exp_mem [0:65535];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_pix   = 0;
    m_frame = 0;
    m_last  = -1;
    m_idx   = 0;
  endtask

  function automatic bit in_window(input int x, input int y);
    return (x >= WX0) && (x < WX0 + WS) && (y >= WY0) && (y < WY0 + WS);
  endfunction

  task automatic send_pix(input int x, input int y, input logic [7:0] l);
    logic        exp_wr;
    logic [15:0] ea;
    int          a;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 11'(x);
    bus.pix_y     = 11'(y);
    bus.pix_luma  = l;
    exp_wr = 1'b0;
    ea     = '0;
    if (m_state == 2 && in_window(x, y)) begin
      a      = WS * (y - WY0) + (x - WX0);
      ea     = 16'(a);
      exp_wr = 1'b1;
      if (a != m_last) m_pix = (m_pix + 1) % 65536;
      m_last     = a;
      exp_mem[a] = l;
      if (a == DEPTH - 1) begin
        m_state = 3;
        m_frame = (m_frame + 1) % 256;
      end
    end else if (m_state == 1 && x == 0 && y == 0) begin
      m_state = 2;
    end
    @(posedge clk);
    #1;
    check("buf_wr_en", 32'(bus.buf_wr_en), 32'(exp_wr));
    if (exp_wr) check("buf_wr_addr_data", {8'b0, bus.buf_wr_addr, bus.buf_wr_data}, {8'b0, ea, l});
    check("cap_done", 32'(bus.cap_done), 32'(m_state == 3));
    bus.pix_valid = 1'b0;
  endtask

  task automatic send_noise();
    send_pix($urandom_range(1, WX0 - 1), $urandom_range(0, 2047), 8'($urandom));
  endtask

  // Raster over the window; stops after npix distinct pixels.
  task automatic send_window(input int npix, input bit dup, input bit rnd_luma, input bit noise);
    int         n = 0;
    logic [7:0] l;
    for (int y = WY0; y < WY0 + WS; y++) begin
      for (int x = WX0; x < WX0 + WS; x++) begin
        if (n >= npix) return;
        l = rnd_luma ? 8'($urandom) : 8'(x + y);
        send_pix(x, y, l);
        if (dup) send_pix(x, y, l);
        if (noise && $urandom_range(0, 9) == 0) send_noise();
        n++;
      end
    end
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en     = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    if (a == REG_CTRL) begin
      if (d[1]) m_state = 0;
      else if (d[0] && (m_state == 0 || m_state == 3)) begin
        m_state = 1;
        m_pix   = 0;
        m_last  = -1;
      end
    end else if (a == REG_INDEX) begin
      m_idx = int'(d[15:0]);
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, input string name, output logic [31:0] got);
    logic [31:0] exp;
    logic [15:0] pc;
    logic [7:0]  fc;
    logic [1:0]  st;
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    pc = 16'(m_pix);
    fc = 8'(m_frame);
    st = 2'(m_state);
    case (a)
      REG_CTRL:   exp = '0;
      REG_STATUS: exp = {pc, fc, 5'b0, (m_state == 3), st};
      REG_INDEX:  exp = 32'(m_idx);
      default: begin
        exp = (m_idx < DEPTH) ? {24'b0, exp_mem[m_idx]} : 32'd0;
`ifdef CAPTURE_AUTOINC_EN
        m_idx = (m_idx >= DEPTH - 1) ? 0 : m_idx + 1;
`endif
      end
    endcase
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    got = bus.readdata;
    check(name, got, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_buf_wr_en", 32'(bus.buf_wr_en), 32'd0);
    check("rst_cap_done", 32'(bus.cap_done), 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          is_wr;
    logic [1:0]  a;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] got;
  logic [31:0] held;
  logic [7:0]  top_byte;

  initial begin
    reset_n       = 1'b1;
    bus.addr      = '0;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.writedata = '0;
    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.pix_luma  = '0;
    for (int i = 0; i < 65536; i++) exp_mem[i] = 8'h00;
    m_reset();
    #2;
    do_reset();

    // Register map in IDLE.
    vecs[0]  = '{1'b0, REG_STATUS, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, REG_INDEX,  32'h0, 32'h0};
    vecs[2]  = '{1'b0, REG_CTRL,   32'h0, 32'h0};
    vecs[3]  = '{1'b1, REG_INDEX,  32'h1234_ABCD, 32'h0};
    vecs[4]  = '{1'b0, REG_INDEX,  32'h0, 32'h0000_ABCD};
    vecs[5]  = '{1'b1, REG_STATUS, 32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{1'b0, REG_STATUS, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, REG_CTRL,   32'h2, 32'h0};
    vecs[8]  = '{1'b0, REG_STATUS, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, REG_DATA,   32'h55, 32'h0};
    vecs[10] = '{1'b1, REG_INDEX,  32'h0, 32'h0};
    vecs[11] = '{1'b0, REG_INDEX,  32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) av_write(vecs[i].a, vecs[i].wdata);
      else begin
        av_read(vecs[i].a, "table_model", got);
        check("table_const", got, vecs[i].exp);
      end
    end

    // Armed: samples before the frame boundary must not write.
    av_write(REG_CTRL, 32'h1);
    send_pix(WX0, WY0, 8'h11);
    for (int i = 0; i < 10; i++) send_pix($urandom_range(1, 2047), $urandom_range(0, 2047), 8'($urandom));
    av_read(REG_STATUS, "armed_status", got);
    check("armed_state", 32'(got[1:0]), 32'd1);
    send_pix(0, 0, 8'h00);
    av_write(REG_CTRL, 32'h1);
    av_read(REG_STATUS, "start_in_capture", got);
    check("capture_state", 32'(got[1:0]), 32'd2);

    send_window(DEPTH, 1'b0, 1'b0, 1'b1);
    send_pix(WX0, WY0, 8'hEE);
    av_read(REG_STATUS, "full_status", got);
    check("full_status_const", got, {16'(DEPTH), 8'd1, 5'b0, 1'b1, 2'd3});
    repeat (3) @(negedge clk);
    check("readdata_hold", bus.readdata, got);

    // Abort part-way through a capture.
    av_write(REG_CTRL, 32'h1);
    send_pix(0, 0, 8'h00);
    send_window(1000, 1'b0, 1'b1, 1'b0);
    av_write(REG_CTRL, 32'h2);
    send_window(20, 1'b0, 1'b1, 1'b0);
    av_read(REG_STATUS, "abort_status", got);
    check("abort_pix_count", 32'(got[31:16]), 32'd1000);
    check("abort_state", 32'(got[1:0]), 32'd0);
    av_write(REG_CTRL, 32'h3);
    av_read(REG_STATUS, "abort_start_status", got);
    check("abort_start_state", 32'(got[1:0]), 32'd0);

    // Every sample duplicated by the synchronizer.
    av_write(REG_CTRL, 32'h1);
    send_pix(0, 0, 8'h00);
    send_window(DEPTH, 1'b1, 1'b1, 1'b1);
    send_window(5, 1'b0, 1'b1, 1'b0);
    av_read(REG_STATUS, "dup_status", got);
    check("dup_status_const", got, {16'(DEPTH), 8'd2, 5'b0, 1'b1, 2'd3});

    // INDEX/DATA readout.
    top_byte = exp_mem[DEPTH - 1];
    av_write(REG_INDEX, 32'(DEPTH - 1));
    av_read(REG_DATA, "data_last_1", got);
    check("data_last_1_const", got, {24'b0, top_byte});
    av_read(REG_DATA, "data_last_2", got);
    av_read(REG_INDEX, "index_after", got);
`ifdef CAPTURE_AUTOINC_EN
    check("index_after_const", got, 32'd1);
`else
    check("index_after_const", got, 32'(DEPTH - 1));
`endif
    av_write(REG_INDEX, 32'd60000);
    av_read(REG_DATA, "data_oob", got);
    check("data_oob_const", got, 32'd0);
    for (int i = 0; i < 20; i++) begin
      av_write(REG_INDEX, 32'($urandom_range(0, DEPTH + 100)));
      av_read(REG_DATA, "data_rand", got);
    end

    // Reset with a write in flight: the buffer must keep its old byte.
    av_write(REG_CTRL, 32'h1);
    send_pix(0, 0, 8'h00);
    send_window(45, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 11'(WX0 + 3);
    bus.pix_y     = 11'(WY0 + 2);
    bus.pix_luma  = ~exp_mem[2 * WS + 3];
    @(posedge clk);
    #1;
    check("inflight_wr_en", 32'(bus.buf_wr_en), 32'd1);
    bus.pix_valid = 1'b0;
    do_reset();
    av_read(REG_STATUS, "post_reset_status", got);
    check("post_reset_status_const", got, 32'd0);
    av_write(REG_INDEX, 32'(2 * WS + 3));
    av_read(REG_DATA, "dropped_write", got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
# capture_controller

Frame-capture sequencer for the 224x224 luma capture field. Sits between the clk-domain pixel stream (output of the VGA-to-clk synchronizer) and the capture buffer RAM. Arms on host command, captures exactly one complete window starting at a frame boundary, then freezes the buffer and exposes it to the Avalon host through an index/data register pair.

## Interface
- WIN_X0, 208, window left column (screen coords)
- WIN_Y0, 128, window top row
- WIN_SIZE, 224, window edge in pixels; buffer depth WIN_SIZE*WIN_SIZE (<= 65535)
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  reset, asynchronous, active-low
- addr  in  2  Avalon register address: 0 CTRL, 1 STATUS, 2 INDEX, 3 DATA
- rd_en  in  1  Avalon read strobe
- wr_en  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- pix_valid  in  1  one-cycle strobe, new synchronized pixel sample
- pix_x, pix_y  in  11 each  screen coordinates of the sample
- pix_luma  in  8  Y-channel value
- buf_wr_en  out  1  buffer write strobe
- buf_wr_addr  out  16  buffer write address
- buf_wr_data  out  8  buffer write data
- buf_rd_addr  out  16  buffer read address (combinational-read RAM)
- buf_rd_data  in  8  buffer read data
- cap_done  out  1  high while state is DONE

## Operation
- States: IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
- CTRL write: bit0 START, bit1 ABORT. ABORT from any state -> IDLE; ABORT wins over simultaneous START. START in IDLE/DONE -> ARMED, clears pix_count; START in ARMED/CAPTURE ignored.
- ARMED -> CAPTURE on pix_valid with pix_x==0 and pix_y==0; no writes in ARMED.
- CAPTURE: pix_valid inside window (WIN_X0<=x<WIN_X0+WIN_SIZE, same for y) writes luma to address WIN_SIZE*(y-WIN_Y0)+(x-WIN_X0), 16-bit arithmetic. Outside-window samples ignored.
- pix_count (16 bit) increments on a window write whose address differs from the previous write address (synchronizer duplicates not counted; writes still issued, idempotent).
- CAPTURE -> DONE on write of the bottom-right pixel (address WIN_SIZE^2-1); frame_count (8 bit, wraps 255->0) increments on that transition.
- DONE: no buffer writes; buffer frozen until next START.
- STATUS read: [1:0] state, [2] cap_done, [15:8] frame_count, [31:16] pix_count.
- INDEX: write loads writedata[15:0]; read returns {16'b0, index}. buf_rd_addr = index.
- DATA read: {24'b0, buf_rd_data} if index < WIN_SIZE^2, else 0. Reads legal in any state.
- CTRL read returns 0. Writes to STATUS/DATA ignored.

## Timing
- Reset values: state IDLE, readdata 0, buf_wr_en 0, buf_wr_addr 0, buf_wr_data 0, index 0, pix_count 0, frame_count 0, cap_done 0.
- readdata: read latency 1; registered on rd_en cycle, holds value otherwise.
- Buffer write: pix_valid at cycle t -> buf_wr_en/addr/data asserted at t+1 for one cycle.
- State changes take effect the edge after the triggering pix_valid or wr_en; cap_done rises the cycle after the final write is issued.
- Reset mid-capture: immediate IDLE, in-flight write dropped.

## Configuration
- CAPTURE_AUTOINC_EN defined: every DATA read increments index after sampling; index WIN_SIZE^2-1 wraps to 0; out-of-range index also wraps to 0. Simultaneous INDEX write and DATA read impossible (single port).
- Undefined: index changes only on INDEX writes.

## Structure
- Package capture_pkg: state enum, register address constants (REG_CTRL..REG_DATA), CTRL bit positions, default window constants.
- Sub-module capture_addr_gen: combinational window test and buffer address computation from pix_x/pix_y.

## Test plan
- Reset, read STATUS and INDEX -> readdata 0 both, cap_done 0.
- START, frame with (0,0) then full raster, luma=(x+y)&0xFF -> writes to addr 0 for (208,128), 50175 for (431,351); DONE; STATUS = {16'd50176, 8'd1, 5'b0, 1'b1, 2'd3}.
- Pixels sent in ARMED before (0,0) -> no buf_wr_en; START during CAPTURE -> no state change.
- ABORT after 1000 window pixels -> IDLE, no further writes, STATUS[31:16]=1000; ABORT+START same write -> IDLE.
- Every sample repeated twice -> pix_count 50176, DONE reached once, frame_count 1.
- INDEX=50175, two DATA reads -> second returns buffer[0] and index 1 with CAPTURE_AUTOINC_EN; both buffer[50175], index unchanged without; INDEX=60000 -> DATA reads 0.
